imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sits directly upstream of mips_16.
- Holds the core in reset while it receives a program image as a byte stream (from the UART receiver or bench driver). Each pair of bytes becomes one 16-bit instruction, written sequentially into instruction memory.
- After a verified checksum it releases the core so execution starts at PC 0 with a fully loaded image.

Parameters:
- ADDR_W, 8, instruction memory address width in words.
- DEPTH, 256, instruction memory capacity in words; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  input byte valid.
- rx_data  in  8  input byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a rising edge.
- reload  in  1  single-cycle pulse; restarts the load from DONE or ERR.
- imem_we  out  1  instruction memory write enable, one-cycle pulse.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  16  write data.
- core_reset  out  1  active-high reset to mips_16.
- done  out  1  image loaded and verified; core running.
- error  out  1  load failed.

Behaviour:
- Reset values while reset is low, asynchronously:
  - state=CNT_HI, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, done=0, error=0.
  - Internal count, word index and checksum are all 0.
  - rx_ready rises on the first clock after reset deasserts.
- Stream format:
  - count high byte, count low byte (N, big-endian word count);
  - N words, each sent high byte then low byte;
  - then 1 checksum byte equal to the XOR of every byte after the count bytes. For N=0 the checksum is 0x00.
- State machine, all transitions on an accepted byte unless noted:
  - CNT_HI: latch N[15:8]. Go to CNT_LO.
  - CNT_LO: latch N[7:0].
    - If N > DEPTH, go to ERR; the byte is consumed.
    - Else if N == 0, go to CSUM.
    - Else go to DATA_HI.
  - DATA_HI: hold the byte and fold it into the checksum. Go to DATA_LO.
  - DATA_LO: fold the byte into the checksum and schedule the write. Go to CSUM if this is word N-1, else DATA_HI.
  - CSUM: on match go to DONE, else ERR.
  - DONE:
    - rx_ready=0, core_reset=0, done=1.
    - Incoming bytes are ignored.
    - Stays here until reload or reset.
  - ERR: rx_ready=0, core_reset=1, error=1. Stays here until reload or reset.
- rx_ready=1 in CNT_HI, CNT_LO, DATA_HI, DATA_LO and CSUM, with no internal backpressure. One byte can be accepted every cycle.
- Write timing:
  - imem_we pulses for exactly the one cycle after the DATA_LO byte is accepted.
  - imem_wdata={hi,lo} and imem_addr=word index during that pulse.
  - The index increments after the write; word k goes to address k.
  - The last write always completes before the checksum byte can be accepted, so core release never overlaps a write.
- Release timing: core_reset falls, and done rises, in the cycle after a matching checksum byte is accepted.
- reload:
  - Honoured only in DONE or ERR.
  - Next cycle: state=CNT_HI, core_reset=1, done=0, error=0, word index and checksum cleared, rx_ready=1.
  - Ignored in every other state.
  - Memory contents are not cleared.
- Reset low at any point, including mid-word or mid-write:
  - Aborts immediately with the reset values above.
  - A partially received word is discarded and imem_we drops to 0 asynchronously.
  - Words already written remain in memory.
- N == DEPTH is legal. The final write goes to address DEPTH-1 and the index never wraps.

Test Plan:
- Reset then stream 00 02 | 12 34 | AB CD | 40 (XOR 12^34^AB^CD=40):
  - writes 0x1234 at addr 0, then 0xABCD at addr 1, one imem_we pulse each;
  - core_reset falls one cycle after the 0x40 byte; done=1.
- Stream 00 01 | 20 01 | 00 (expected checksum 0x21):
  - error=1 and core_reset stays 1;
  - reload pulse, then 00 01 20 01 21 → done=1 and addr 0 = 0x2001.
- Stream 00 00 | 00:
  - no imem_we pulses;
  - done=1 one cycle after the checksum byte.
- Stream 01 01 with DEPTH=256:
  - error=1 right after the second byte; rx_ready=0; no writes.
- Gapped rx_valid, back-to-back bytes, then reset asserted low between DATA_HI and DATA_LO of word 3:
  - asynchronously: imem_we=0, core_reset=1, rx_ready=0;
  - restart and a full load of 3 words succeeds.
- After done, drive rx_valid with byte 0xFF:
  - rx_ready=0, no writes, core_reset stays 0.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if
//   Byte-stream input and instruction-memory write bus of the boot loader.
//   master : loader side (accepts bytes, drives memory writes)
//   slave  : environment side (drives bytes, observes memory writes)
//   rx_valid/rx_data/rx_ready : byte stream handshake
//   imem_we/imem_addr/imem_wdata : one-word write port into instruction memory
interface imem_boot_loader_if #(
   parameter int ADDR_W = 8
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;

   modport master (
      input  rx_valid, rx_data,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output rx_valid, rx_data,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Holds mips_16 in reset while a program image arrives as a byte stream:
//   2-byte big-endian word count N, N words (high byte first), 1 XOR
//   checksum byte over the word bytes. Words are written to addresses
//   0..N-1; on a matching checksum the core is released.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   bus        : byte stream in, instruction-memory write port out
//   reload     : one-cycle pulse, restarts loading from DONE or ERR
//   core_reset : active-high reset to the core
//   done       : image loaded and verified, core running
//   error      : load failed (oversize count or bad checksum)
module imem_boot_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   imem_boot_loader_if.master     bus,
   input  logic                   reload,
   output logic                   core_reset,
   output logic                   done,
   output logic                   error
);
   localparam logic [2:0] CNT_HI  = 3'd0;
   localparam logic [2:0] CNT_LO  = 3'd1;
   localparam logic [2:0] DATA_HI = 3'd2;
   localparam logic [2:0] DATA_LO = 3'd3;
   localparam logic [2:0] CSUM    = 3'd4;
   localparam logic [2:0] DONE    = 3'd5;
   localparam logic [2:0] ERR     = 3'd6;

   logic [2:0]        state, state_nxt;
   logic [15:0]       cnt;
   logic [ADDR_W-1:0] idx;
   logic [7:0]        csum;
   logic [7:0]        hi_byte;
   logic              acc;
   logic [15:0]       n_new;
   logic              last_word;
   logic              reload_ok;

   // rx_ready is a registered copy of "state accepts bytes", so acc is
   // only ever true in CNT_HI..CSUM.
   assign acc       = bus.rx_valid && bus.rx_ready;
   assign n_new     = {cnt[15:8], bus.rx_data};
   assign last_word = (32'(idx) == (32'(cnt) - 32'd1));
   assign reload_ok = reload && ((state == DONE) || (state == ERR));

   always_comb begin
      state_nxt = state;
      case (state)
         CNT_HI:  if (acc) state_nxt = CNT_LO;
         CNT_LO:
            if (acc) begin
               if (32'(n_new) > 32'(DEPTH)) state_nxt = ERR;
               else if (n_new == 16'd0)     state_nxt = CSUM;
               else                         state_nxt = DATA_HI;
            end
         DATA_HI: if (acc) state_nxt = DATA_LO;
         DATA_LO: if (acc) state_nxt = last_word ? CSUM : DATA_HI;
         CSUM:    if (acc) state_nxt = (bus.rx_data == csum) ? DONE : ERR;
         DONE:    if (reload) state_nxt = CNT_HI;
         ERR:     if (reload) state_nxt = CNT_HI;
         default: state_nxt = CNT_HI;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= CNT_HI;
         cnt            <= '0;
         idx            <= '0;
         csum           <= '0;
         hi_byte        <= '0;
         bus.rx_ready   <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         core_reset     <= 1'b1;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         state        <= state_nxt;
         bus.rx_ready <= (state_nxt == CNT_HI) || (state_nxt == CNT_LO) ||
                         (state_nxt == DATA_HI) || (state_nxt == DATA_LO) ||
                         (state_nxt == CSUM);
         core_reset   <= (state_nxt != DONE);
         done         <= (state_nxt == DONE);
         error        <= (state_nxt == ERR);
         bus.imem_we  <= 1'b0;
         if (acc) begin
            case (state)
               CNT_HI:  cnt[15:8] <= bus.rx_data;
               CNT_LO:  cnt[7:0]  <= bus.rx_data;
               DATA_HI: begin
                  hi_byte <= bus.rx_data;
                  csum    <= csum ^ bus.rx_data;
               end
               DATA_LO: begin
                  csum           <= csum ^ bus.rx_data;
                  bus.imem_we    <= 1'b1;
                  bus.imem_addr  <= idx;
                  bus.imem_wdata <= {hi_byte, bus.rx_data};
                  // Hold on the last word so N == DEPTH never wraps idx.
                  if (!last_word) idx <= idx + 1'b1;
               end
               default: ;
            endcase
         end
         if (reload_ok) begin
            cnt  <= '0;
            idx  <= '0;
            csum <= '0;
         end
      end
   end
endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
   logic clk;
   logic reset;
   logic reload;
   logic core_reset, done, error;
   int   n_chk, n_fail;
   int   wr_cnt;
   int   last_addr;
   logic [15:0] mem [0:255];

   imem_boot_loader_if #(.ADDR_W(8)) bus ();

   imem_boot_loader #(.ADDR_W(8), .DEPTH(256)) dut (
      .clk(clk), .reset(reset), .bus(bus), .reload(reload),
      .core_reset(core_reset), .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.imem_we) begin
         mem[bus.imem_addr] <= bus.imem_wdata;
         wr_cnt             <= wr_cnt + 1;
         last_addr          <= int'(bus.imem_addr);
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Drive one byte; returns #1 after the accepting edge.
   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      while (!bus.rx_ready && t < 20) begin
         @(posedge clk); #1; t++;
      end
      if (!bus.rx_ready) check("rdy_tmo", 32'(bus.rx_ready), 32'd1);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk); #1;
      reload = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int base;
      logic [7:0] cs;
      logic [7:0] k8;
      n_chk = 0; n_fail = 0; wr_cnt = 0; last_addr = -1;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      reset = 1'b0; reload = 1'b0;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

      // Reset state
      #12;
      check("rst_rx_ready",   32'(bus.rx_ready),   32'd0);
      check("rst_imem_we",    32'(bus.imem_we),    32'd0);
      check("rst_imem_addr",  32'(bus.imem_addr),  32'd0);
      check("rst_imem_wdata", 32'(bus.imem_wdata), 32'd0);
      check("rst_core_reset", 32'(core_reset),     32'd1);
      check("rst_done",       32'(done),           32'd0);
      check("rst_error",      32'(error),          32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("rdy_after_rst", 32'(bus.rx_ready), 32'd1);

      // Two-word image
      base = wr_cnt;
      send(8'h00); send(8'h02); send(8'h12); send(8'h34);
      check("w0_we",    32'(bus.imem_we),    32'd1);
      check("w0_addr",  32'(bus.imem_addr),  32'd0);
      check("w0_wdata", 32'(bus.imem_wdata), 32'h1234);
      send(8'hAB); send(8'hCD);
      check("w1_we",    32'(bus.imem_we),    32'd1);
      check("w1_addr",  32'(bus.imem_addr),  32'd1);
      check("w1_wdata", 32'(bus.imem_wdata), 32'hABCD);
      check("pre_cs_core_reset", 32'(core_reset), 32'd1);
      send(8'h40);
      check("t1_we_off",      32'(bus.imem_we), 32'd0);
      check("t1_done",        32'(done),        32'd1);
      check("t1_core_reset",  32'(core_reset),  32'd0);
      check("t1_rx_ready",    32'(bus.rx_ready),32'd0);
      check("t1_mem0",        32'(mem[0]),      32'h1234);
      check("t1_mem1",        32'(mem[1]),      32'hABCD);
      check("t1_wr_count",    32'(wr_cnt - base), 32'd2);

      // Bytes after done are ignored
      base = wr_cnt;
      bus.rx_valid = 1'b1; bus.rx_data = 8'hFF;
      idle(3);
      bus.rx_valid = 1'b0;
      check("done_ff_rx_ready",   32'(bus.rx_ready), 32'd0);
      check("done_ff_core_reset", 32'(core_reset),   32'd0);
      check("done_ff_done",       32'(done),         32'd1);
      check("done_ff_wr",         32'(wr_cnt - base),32'd0);

      // Bad checksum, then reload and good checksum
      pulse_reload();
      check("rl_done",       32'(done),         32'd0);
      check("rl_core_reset", 32'(core_reset),   32'd1);
      check("rl_rx_ready",   32'(bus.rx_ready), 32'd1);
      send(8'h00); send(8'h01); send(8'h20); send(8'h01); send(8'h00);
      check("badcs_error",      32'(error),        32'd1);
      check("badcs_core_reset", 32'(core_reset),   32'd1);
      check("badcs_rx_ready",   32'(bus.rx_ready), 32'd0);
      pulse_reload();
      check("rl2_error", 32'(error), 32'd0);
      send(8'h00); send(8'h01); send(8'h20); send(8'h01); send(8'h21);
      check("goodcs_done", 32'(done),   32'd1);
      check("goodcs_mem0", 32'(mem[0]), 32'h2001);

      // Empty image
      pulse_reload();
      base = wr_cnt;
      send(8'h00); send(8'h00);
      check("n0_not_done", 32'(done), 32'd0);
      send(8'h00);
      check("n0_done",  32'(done),          32'd1);
      check("n0_no_wr", 32'(wr_cnt - base), 32'd0);

      // Oversize count
      pulse_reload();
      base = wr_cnt;
      send(8'h01); send(8'h01);
      check("big_error",    32'(error),          32'd1);
      check("big_rx_ready", 32'(bus.rx_ready),   32'd0);
      check("big_no_wr",    32'(wr_cnt - base),  32'd0);

      // Gapped stream, abort by reset inside word 3
      pulse_reload();
      base = wr_cnt;
      send(8'h00); idle(2); send(8'h04);
      send(8'hA1); idle(1); send(8'hB2);
      send(8'hC3); send(8'hD4);
      idle(3); send(8'hE5); send(8'hF6);
      send(8'h07);
      #2 reset = 1'b0;
      #1;
      check("abort_we",         32'(bus.imem_we),  32'd0);
      check("abort_core_reset", 32'(core_reset),   32'd1);
      check("abort_rx_ready",   32'(bus.rx_ready), 32'd0);
      check("abort_wr",         32'(wr_cnt - base),32'd3);
      check("abort_mem2",       32'(mem[2]),       32'hE5F6);
      @(negedge clk); reset = 1'b1;

      // Reset during the write pulse drops imem_we at once
      send(8'h00); send(8'h01); send(8'h55); send(8'h66);
      check("midwr_we_on", 32'(bus.imem_we), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("midwr_we_off", 32'(bus.imem_we), 32'd0);
      @(negedge clk); reset = 1'b1;

      // Full 3-word load after restart (11^22^33^44^55^66 = 77)
      base = wr_cnt;
      send(8'h00); send(8'h03);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
      send(8'h77);
      check("re3_done", 32'(done),          32'd1);
      check("re3_wr",   32'(wr_cnt - base), 32'd3);
      check("re3_mem0", 32'(mem[0]),        32'h1122);
      check("re3_mem1", 32'(mem[1]),        32'h3344);
      check("re3_mem2", 32'(mem[2]),        32'h5566);

      // N == DEPTH: word k = {k, k^5A}
      pulse_reload();
      base = wr_cnt;
      cs = 8'h00;
      send(8'h01); send(8'h00);
      for (int k = 0; k < 256; k++) begin
         k8 = 8'(k);
         send(k8);
         send(k8 ^ 8'h5A);
         cs = cs ^ k8 ^ (k8 ^ 8'h5A);
      end
      send(cs);
      check("full_done",   32'(done),          32'd1);
      check("full_wr",     32'(wr_cnt - base), 32'd256);
      check("full_last",   32'(last_addr),     32'd255);
      check("full_mem0",   32'(mem[0]),        32'h005A);
      check("full_mem255", 32'(mem[255]),      32'hFFA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
